// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: control FSM sitting between a UART RX/TX pair and an ALU.
// It collects operand A, operand B and an opcode byte, validates the opcode,
// fires the ALU and sends the result back out (or an error byte for an
// illegal opcode). It also aborts a transaction on an inter-byte timeout and
// flags bytes that arrive while it is busy.
module uart_alu_sequencer #(
    parameter int                  NB_DATA     = 8,
    parameter int                  NB_OP       = 6,
    parameter int                  ALU_LAT     = 1,
    parameter int                  TIMEOUT_CYC = 50000000,
    parameter logic [NB_DATA-1:0]  ERR_CODE    = NB_DATA'(8'hFF)
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_alu_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic [3:0]         o_leds,
    output logic               o_err,
    output logic               o_overrun
);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND,
        S_WAIT_TX
    } state_t;

    localparam logic [3:0] LEDS_A    = 4'b0001;
    localparam logic [3:0] LEDS_B    = 4'b0010;
    localparam logic [3:0] LEDS_OP   = 4'b0100;
    localparam logic [3:0] LEDS_BUSY = 4'b1000;

    // Inter-byte timeout counter; a zero TIMEOUT_CYC disables the timeout.
    localparam bit            T_EN   = (TIMEOUT_CYC > 0);
    localparam int            TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    // ALU latency counter; ALU_LAT is at least 1.
    localparam int            LW     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [LW-1:0] L_LAST = LW'(ALU_LAT - 1);

    state_t        state;
    logic [TW-1:0] t_cnt;
    logic [LW-1:0] l_cnt;

    // Only the listed opcodes are executed; anything else gets an error reply.
    function automatic logic op_legal(input logic [NB_OP-1:0] op);
        return op inside {NB_OP'(6'h20), NB_OP'(6'h22), NB_OP'(6'h24), NB_OP'(6'h25),
                          NB_OP'(6'h26), NB_OP'(6'h27), NB_OP'(6'h03), NB_OP'(6'h02)};
    endfunction

    logic [NB_OP-1:0] rx_op;
    assign rx_op = i_rx_data[NB_OP-1:0];

    // Transaction FSM: every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_WAIT_A;
            t_cnt       <= '0;
            l_cnt       <= '0;
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_op        <= '0;
            o_alu_valid <= 1'b0;
            o_tx_data   <= '0;
            o_tx_start  <= 1'b0;
            o_leds      <= LEDS_A;
            o_err       <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch sees
            // the pre-edge register values regardless of statement order.
            o_alu_valid <= 1'b0;
            o_tx_start  <= 1'b0;

            if (i_rx_done && (state inside {S_EXEC, S_SEND, S_WAIT_TX}))
                o_overrun <= 1'b1;

            case (state)
                S_WAIT_A: begin
                    if (i_rx_done) begin
                        o_data_a <= i_rx_data;
                        o_err    <= 1'b0;
                        t_cnt    <= '0;
                        state    <= S_WAIT_B;
                        o_leds   <= LEDS_B;
                    end
                end

                S_WAIT_B: begin
                    if (i_rx_done) begin
                        o_data_b <= i_rx_data;
                        t_cnt    <= '0;
                        state    <= S_WAIT_OP;
                        o_leds   <= LEDS_OP;
                    end else if (T_EN && t_cnt == T_LAST) begin
                        o_err  <= 1'b1;
                        state  <= S_WAIT_A;
                        o_leds <= LEDS_A;
                    end else if (T_EN) begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end

                S_WAIT_OP: begin
                    if (i_rx_done) begin
                        t_cnt  <= '0;
                        o_leds <= LEDS_BUSY;
                        if (op_legal(rx_op)) begin
                            o_op        <= rx_op;
                            o_alu_valid <= 1'b1;
                            l_cnt       <= '0;
                            state       <= S_EXEC;
                        end else begin
                            o_err      <= 1'b1;
                            o_tx_data  <= ERR_CODE;
                            o_tx_start <= 1'b1;
                            state      <= S_SEND;
                        end
                    end else if (T_EN && t_cnt == T_LAST) begin
                        o_err  <= 1'b1;
                        state  <= S_WAIT_A;
                        o_leds <= LEDS_A;
                    end else if (T_EN) begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end

                S_EXEC: begin
                    if (l_cnt == L_LAST) begin
                        o_tx_data  <= i_alu_result;
                        o_tx_start <= 1'b1;
                        state      <= S_SEND;
                    end else begin
                        l_cnt <= l_cnt + 1'b1;
                    end
                end

                // o_tx_start was raised on entry; it drops back here after one cycle.
                S_SEND: begin
                    state <= S_WAIT_TX;
                end

                S_WAIT_TX: begin
                    if (i_tx_done) begin
                        state  <= S_WAIT_A;
                        o_leds <= LEDS_A;
                    end
                end

                default: begin
                    state  <= S_WAIT_A;
                    o_leds <= LEDS_A;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
Control FSM between the UART receiver/transmitter and the ALU.
- Collects three received bytes in order: operand A, operand B, opcode.
- Validates the opcode, fires a one-cycle ALU valid pulse and waits a fixed ALU latency.
- Captures the result and sends it back through the UART TX start/done handshake.
- Adds an inter-byte timeout, an error reply for illegal opcodes, and overrun flagging.

Parameters:
NB_DATA, 8, data/operand/result width
NB_OP, 6, ALU opcode width (low NB_OP bits of the opcode byte)
ALU_LAT, 1, cycles from o_alu_valid to result sampling (min 1)
TIMEOUT_CYC, 50000000, idle cycles allowed in S_WAIT_B/S_WAIT_OP before abort; 0 disables
ERR_CODE, 8'hFF, byte transmitted on illegal opcode

Ports:
clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse per received byte
i_alu_result  in  NB_DATA  ALU result
i_tx_done  in  1  one-cycle pulse, TX finished a byte
o_data_a  out  NB_DATA  operand A to ALU
o_data_b  out  NB_DATA  operand B to ALU
o_op  out  NB_OP  opcode to ALU
o_alu_valid  out  1  one-cycle ALU execute pulse
o_tx_data  out  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done
o_tx_start  out  1  one-cycle TX start pulse
o_leds  out  4  state indicator
o_err  out  1  last transaction failed (illegal op or timeout)
o_overrun  out  1  sticky: byte received while busy

Behaviour:
- Reset (async): state S_WAIT_A; o_leds=4'b0001; all other outputs and registers 0; timeout and latency counters cleared. Reset mid-operation aborts immediately; o_tx_start/o_alu_valid fall in the same instant.
- All outputs are registered.
- States and o_leds:
  - S_WAIT_A=0001, S_WAIT_B=0010, S_WAIT_OP=0100.
  - S_EXEC, S_SEND and S_WAIT_TX all show 1000.
- S_WAIT_A:
  - On i_rx_done at edge n: o_data_a<=i_rx_data, o_err<=0, state S_WAIT_B at n+1.
  - No timeout applies in this state.
- S_WAIT_B:
  - On i_rx_done: o_data_b<=i_rx_data, next state S_WAIT_OP.
- S_WAIT_OP:
  - Legal opcode set (NB_OP bits): 6'h20 ADD, 6'h22 SUB, 6'h24 AND, 6'h25 OR, 6'h26 XOR, 6'h27 NOR, 6'h03 SRA, 6'h02 SRL. Upper byte bits are ignored.
  - Legal opcode at edge n: o_op latched; o_alu_valid=1 during cycle n+1 only; state S_EXEC.
  - Illegal opcode: o_op unchanged; o_err<=1; o_tx_data<=ERR_CODE; state S_SEND at n+1; no o_alu_valid.
- Timeout (S_WAIT_B and S_WAIT_OP):
  - Counter clears on entry and on every i_rx_done.
  - After TIMEOUT_CYC consecutive cycles without i_rx_done: state S_WAIT_A, o_err<=1, nothing transmitted.
  - i_rx_done in the expiry cycle wins: byte accepted, no timeout.
- S_EXEC:
  - Lasts ALU_LAT cycles, starting at n+1.
  - i_alu_result is sampled into o_tx_data at the last of those cycles; then S_SEND.
  - With ALU_LAT=1: valid at n+1, o_tx_start at n+2.
- S_SEND: o_tx_start=1 for exactly one cycle, then S_WAIT_TX.
- S_WAIT_TX:
  - Hold until i_tx_done, then S_WAIT_A. No timeout.
  - i_tx_done outside S_WAIT_TX is ignored.
- i_rx_done in S_EXEC/S_SEND/S_WAIT_TX: byte dropped, o_overrun<=1. Cleared only by reset.
- o_data_a/o_data_b/o_op hold their values until overwritten; the ALU input is stable between transactions.

Test Plan:
- Reset, then bytes 8'h05, 8'h03, 8'h20; bench ALU returns 8'h08 one cycle after valid:
  - o_alu_valid one cycle after the op byte; o_tx_start one cycle later with o_tx_data=8'h08.
  - After i_tx_done: o_leds=0001, o_err=0.
- Bytes 8'h10, 8'h01, 8'h3F:
  - No o_alu_valid; o_err=1; o_tx_start next cycle with o_tx_data=8'hFF; return to S_WAIT_A after i_tx_done.
- TIMEOUT_CYC=20; send 8'h07, then silence:
  - Exactly 20 cycles later state S_WAIT_A, o_err=1, no o_tx_start.
  - Repeat with a byte arriving on cycle 20: accepted, o_leds=0100.
- Byte pulse during S_WAIT_TX:
  - o_overrun=1 and stays set; transaction completes normally; next A byte accepted.
- ALU_LAT=3:
  - Result sampled 3 cycles after o_alu_valid; o_tx_start on the 4th cycle.
  - Result changes before sampling are not captured.
- Assert i_rst in S_WAIT_TX with o_tx_data=8'h08:
  - All outputs 0 immediately, o_leds=0001; next three bytes run a full transaction.
